sd_spi_initializer: RTL and testbench
=====================================

Name: sd_spi_initializer

Overview:
- Brings an SD card from power-up into SPI data-transfer mode before any block writes are issued.
- Issues the power-up dummy clocks, then CMD0, CMD8, and a CMD55/ACMD41 loop; checks each response.
- Sits directly upstream of the SD block writer: o_done drives the writer's start input.
- Shares the card's MOSI/MISO lines with the writer through an external mux selected by o_busy.

Parameters:
- DUMMY_CLOCKS, 80, i_s_clk cycles with CS high and MOSI=1 after start.
- RESP_TIMEOUT, 80, cycles allowed from the command's last bit to the response start bit (MISO=0).
- ACMD41_RETRIES, 1000, maximum CMD55/ACMD41 pairs before giving up.
- GAP_CLOCKS, 8, idle cycles (MOSI=1, CS low) after each response before the next command.

Ports:
- i_s_clk  in  1  SPI bit clock, also the card SCK; all logic on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle or level request to begin init; sampled only in sIdle.
- MISO  in  1  card data out, sampled on rising edge.
- MOSI  out  1  card data in, updated on rising edge.
- o_cs_n  out  1  card chip select, active low.
- o_busy  out  1  high from the start-accept cycle until sDone/sError.
- o_done  out  1  level, high in sDone; writer start.
- o_error  out  1  level, high in sError.
- o_8_error_code  out  8  failing step: 01 CMD0, 02 CMD8, 03 ACMD41 retries, 04 timeout.
- o_8_LED  out  8  last R1 byte captured, for board LEDs.

Behaviour:
- Reset values: MOSI=1, o_cs_n=1, o_busy=0, o_done=0, o_error=0, o_8_error_code=00, o_8_LED=00, state sIdle.
- States: sIdle, sPowerUp, sCmd0, sWaitCmd0, sCmd8, sWaitCmd8, sCmd55, sWaitCmd55, sAcmd41, sWaitAcmd41, sGap, sDone, sError.
- sIdle -> sPowerUp on i_start.
- sPowerUp: exactly DUMMY_CLOCKS cycles with o_cs_n=1, MOSI=1; then o_cs_n falls and sCmd0 starts.
- Command frames are 48 bits, MSB first, one bit per cycle, with o_cs_n=0:
  - CMD0 = 40 00000000 95
  - CMD8 = 48 000001AA 87
  - CMD55 = 77 00000000 65
  - ACMD41 = 69 40000000 77
- Wait states:
  - After the 48th bit, MOSI=1 and MISO is sampled each cycle.
  - The first 0 begins the response: it is bit 7 of R1, and bits shift in MSB first.
  - R1 is 8 bits; R7 (after CMD8) is 40 bits.
  - No start bit within RESP_TIMEOUT cycles -> sError, code 04.
- CMD0: R1 == 01 -> sGap then sCmd8; otherwise sError, code 01.
- CMD8: requires R1 == 01 and R7[11:0] == 1AA; otherwise sError, code 02 (v1 cards unsupported).
- CMD55: any R1 with bit 7 == 0 continues to sAcmd41.
- ACMD41:
  - R1 == 00 -> sDone.
  - R1 == 01 -> increment the retry counter and loop to sCmd55 via sGap.
  - Retry counter reaching ACMD41_RETRIES -> sError, code 03.
  - Any other R1 -> sError, code 03.
- sGap: GAP_CLOCKS cycles, MOSI=1, o_cs_n=0.
- o_8_LED updates the cycle after each R1 completes.
- sDone and sError:
  - o_cs_n=0 in sDone (the writer needs CS held low); o_cs_n=1 in sError.
  - Both are terminal until reset; i_start is ignored there.
- Reset mid-command: MOSI=1, o_cs_n=1 immediately (asynchronous); the counters and the retry counter clear.
- Counter widths: ceil(log2) of their respective maxima; no wrap is possible inside a state.

Decomposition:
- Shared package holds:
  - state encodings (5-bit, matching the writer's encoding width);
  - the four 48-bit command constants;
  - the error codes;
  - the R1 values 00 and 01.
- One sub-module, sd_cmd_engine:
  - loads a 48-bit command and shifts it out;
  - waits up to RESP_TIMEOUT for the start bit;
  - captures 8 or 40 response bits;
  - reports done, timeout, and the response.
- The top level is the sequencing FSM plus the retry counter.

Test Plan:
- Nominal card (CMD0 -> 01, CMD8 -> 01 000001AA, ACMD41 -> 01 twice then 00) -> 80 CS-high clocks, 3 CMD55/ACMD41 pairs, o_done=1, o_8_LED=00, o_error=0.
- Card never answers CMD0 (MISO=1) -> o_error=1, o_8_error_code=04 exactly RESP_TIMEOUT cycles after the 48th CMD0 bit, o_cs_n=1.
- CMD8 echo 000001AB -> o_error=1, code 02, no CMD55 transmitted.
- ACMD41 always 01 with ACMD41_RETRIES=4 -> exactly 4 pairs sent, then code 03.
- Bit check: capture MOSI during CMD0 -> 0x400000000095 MSB first, with o_cs_n=0 for all 48 cycles.
- Assert i_reset during the 20th bit of CMD8 -> MOSI=1 and o_cs_n=1 in the same cycle; a subsequent i_start replays the full sequence from sPowerUp.

Source files
------------

// File: rtl/sd_spi_initializer_pkg.sv
// rtl/sd_spi_initializer_pkg.sv - shared states, command frames, error codes and R1 values for SD SPI init
package sd_spi_initializer_pkg;

    // 5-bit encoding so the state can be observed alongside the block writer's.
    typedef enum logic [4:0] {
        S_IDLE        = 5'd0,
        S_POWERUP     = 5'd1,
        S_CMD0        = 5'd2,
        S_WAIT_CMD0   = 5'd3,
        S_CMD8        = 5'd4,
        S_WAIT_CMD8   = 5'd5,
        S_CMD55       = 5'd6,
        S_WAIT_CMD55  = 5'd7,
        S_ACMD41      = 5'd8,
        S_WAIT_ACMD41 = 5'd9,
        S_GAP         = 5'd10,
        S_DONE        = 5'd11,
        S_ERROR       = 5'd12
    } state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_SEND,
        E_WAIT,
        E_RECV
    } eng_phase_t;

    localparam logic [47:0] CMD0_FRAME   = 48'h40_0000_0000_95;
    localparam logic [47:0] CMD8_FRAME   = 48'h48_0000_01AA_87;
    localparam logic [47:0] CMD55_FRAME  = 48'h77_0000_0000_65;
    localparam logic [47:0] ACMD41_FRAME = 48'h69_4000_0000_77;

    localparam logic [7:0] ERR_CMD0    = 8'h01;
    localparam logic [7:0] ERR_CMD8    = 8'h02;
    localparam logic [7:0] ERR_ACMD41  = 8'h03;
    localparam logic [7:0] ERR_TIMEOUT = 8'h04;

    localparam logic [7:0] R1_READY = 8'h00;
    localparam logic [7:0] R1_IDLE  = 8'h01;

    // R7 check: R1 byte must be idle and the 12-bit voltage/check-pattern echo must match.
    localparam logic [39:0] R7_MASK   = 40'hFF_0000_0FFF;
    localparam logic [39:0] R7_EXPECT = 40'h01_0000_01AA;

    function automatic logic [47:0] cmd_frame(input state_t s);
        case (s)
            S_CMD8:   cmd_frame = CMD8_FRAME;
            S_CMD55:  cmd_frame = CMD55_FRAME;
            S_ACMD41: cmd_frame = ACMD41_FRAME;
            default:  cmd_frame = CMD0_FRAME;
        endcase
    endfunction

endpackage

// File: rtl/sd_spi_initializer_if.sv
// rtl/sd_spi_initializer_if.sv - control and SPI pin bundle of the SD SPI initializer
// master: drives i_start and MISO (system / card side); slave: the initializer itself.
interface sd_spi_initializer_if;
    logic       i_start;
    logic       MISO;
    logic       MOSI;
    logic       o_cs_n;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [7:0] o_8_error_code;
    logic [7:0] o_8_LED;

    modport master (
        output i_start, MISO,
        input  MOSI, o_cs_n, o_busy, o_done, o_error, o_8_error_code, o_8_LED
    );

    modport slave (
        input  i_start, MISO,
        output MOSI, o_cs_n, o_busy, o_done, o_error, o_8_error_code, o_8_LED
    );
endinterface

// File: rtl/sd_spi_initializer_cmd_engine.sv
// rtl/sd_spi_initializer_cmd_engine.sv - shifts out one 48-bit SD command and captures its R1/R7 response
// Ports: clk/rst, load+cmd+long_resp start a command; miso in, mosi out;
// sent/timeout/done/r1_done are single-cycle flags valid on the edge they describe; r1/resp carry the data.
module sd_cmd_engine
    import sd_spi_initializer_pkg::*;
#(
    parameter int RESP_TIMEOUT = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [47:0] cmd,
    input  logic        long_resp,
    input  logic        miso,
    output logic        mosi,
    output logic        sent,
    output logic        timeout,
    output logic        done,
    output logic        r1_done,
    output logic [7:0]  r1,
    output logic [39:0] resp
);
    localparam int CW = $clog2(RESP_TIMEOUT > 48 ? RESP_TIMEOUT : 48);

    eng_phase_t  phase;
    logic [47:0] sh;
    logic [38:0] rsh;
    logic [CW-1:0] cnt;
    logic        long_q;
    logic        mosi_q;
    logic [CW-1:0] last_bit;

    // Flags look at the current MISO so the sequencer reacts on the very edge
    // that samples the deciding bit.
    assign last_bit = long_q ? CW'(39) : CW'(7);
    assign sent     = (phase == E_SEND) && (cnt == CW'(46));
    assign timeout  = (phase == E_WAIT) && miso && (cnt == CW'(RESP_TIMEOUT - 1));
    assign done     = (phase == E_RECV) && (cnt == last_bit);
    assign r1_done  = (phase == E_RECV) && (cnt == CW'(7));
    assign r1       = {rsh[6:0], miso};
    assign resp     = {rsh, miso};
    assign mosi     = mosi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= E_IDLE;
            sh     <= '0;
            rsh    <= '0;
            cnt    <= '0;
            long_q <= 1'b0;
            mosi_q <= 1'b1;
        end else begin
            case (phase)
                E_IDLE: begin
                    mosi_q <= 1'b1;
                    if (load) begin
                        // Bit 47 goes out on the load edge itself.
                        mosi_q <= cmd[47];
                        sh     <= {cmd[46:0], 1'b1};
                        cnt    <= '0;
                        long_q <= long_resp;
                        phase  <= E_SEND;
                    end
                end
                E_SEND: begin
                    mosi_q <= sh[47];
                    sh     <= {sh[46:0], 1'b1};
                    if (cnt == CW'(46)) begin
                        phase <= E_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                E_WAIT: begin
                    mosi_q <= 1'b1;
                    if (!miso) begin
                        // The start bit is R1 bit 7 and is kept.
                        rsh   <= {rsh[37:0], 1'b0};
                        cnt   <= CW'(1);
                        phase <= E_RECV;
                    end else if (timeout) begin
                        phase <= E_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                E_RECV: begin
                    mosi_q <= 1'b1;
                    rsh    <= {rsh[37:0], miso};
                    if (done) phase <= E_IDLE;
                    else      cnt   <= cnt + 1'b1;
                end
                default: phase <= E_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/sd_spi_initializer.sv
// rtl/sd_spi_initializer.sv - SD card SPI-mode init sequencer: dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop
// Ports: i_s_clk (SPI bit clock, rising edge), i_reset (async, active high),
// bus (slave modport): i_start, MISO in; MOSI, o_cs_n, o_busy, o_done, o_error, o_8_error_code, o_8_LED out.
module sd_spi_initializer
    import sd_spi_initializer_pkg::*;
#(
    parameter int DUMMY_CLOCKS   = 80,
    parameter int RESP_TIMEOUT   = 80,
    parameter int ACMD41_RETRIES = 1000,
    parameter int GAP_CLOCKS     = 8
) (
    input  logic               i_s_clk,
    input  logic               i_reset,
    sd_spi_initializer_if.slave bus
);
    localparam int TW = $clog2(DUMMY_CLOCKS > GAP_CLOCKS ? DUMMY_CLOCKS : GAP_CLOCKS);
    localparam int RW = $clog2(ACMD41_RETRIES + 1);

    state_t        state;
    state_t        gap_next;
    state_t        load_target;
    logic [TW-1:0] cnt;
    logic [RW-1:0] retry;
    logic          cs_n_q, busy_q, done_q, error_q;
    logic [7:0]    code_q, led_q;

    logic          eng_load, eng_long, eng_mosi, eng_sent, eng_timeout, eng_done, eng_r1_done;
    logic [47:0]   eng_cmd;
    logic [7:0]    eng_r1;
    logic [39:0]   eng_resp;

    logic          fail, to_gap, finish;
    logic [7:0]    fail_code;
    state_t        gap_target;

    // The engine is loaded on the last idle cycle so bit 47 lands right after it.
    assign eng_load    = ((state == S_POWERUP) && (cnt == TW'(DUMMY_CLOCKS - 1))) ||
                         ((state == S_GAP)     && (cnt == TW'(GAP_CLOCKS - 1)));
    assign load_target = (state == S_POWERUP) ? S_CMD0 : gap_next;
    assign eng_cmd     = cmd_frame(load_target);
    assign eng_long    = (load_target == S_CMD8);

    sd_cmd_engine #(.RESP_TIMEOUT(RESP_TIMEOUT)) u_engine (
        .clk       (i_s_clk),
        .rst       (i_reset),
        .load      (eng_load),
        .cmd       (eng_cmd),
        .long_resp (eng_long),
        .miso      (bus.MISO),
        .mosi      (eng_mosi),
        .sent      (eng_sent),
        .timeout   (eng_timeout),
        .done      (eng_done),
        .r1_done   (eng_r1_done),
        .r1        (eng_r1),
        .resp      (eng_resp)
    );

    // Response evaluation for the four wait states.
    always_comb begin
        fail       = 1'b0;
        fail_code  = 8'h00;
        to_gap     = 1'b0;
        gap_target = S_CMD8;
        finish     = 1'b0;
        if ((state == S_WAIT_CMD0) || (state == S_WAIT_CMD8) ||
            (state == S_WAIT_CMD55) || (state == S_WAIT_ACMD41)) begin
            if (eng_timeout) begin
                fail      = 1'b1;
                fail_code = ERR_TIMEOUT;
            end else if (eng_done) begin
                case (state)
                    S_WAIT_CMD0: begin
                        if (eng_resp[7:0] == R1_IDLE) to_gap = 1'b1;
                        else begin fail = 1'b1; fail_code = ERR_CMD0; end
                        gap_target = S_CMD8;
                    end
                    S_WAIT_CMD8: begin
                        if ((eng_resp & R7_MASK) == R7_EXPECT) to_gap = 1'b1;
                        else begin fail = 1'b1; fail_code = ERR_CMD8; end
                        gap_target = S_CMD55;
                    end
                    S_WAIT_CMD55: begin
                        // A captured R1 always has bit 7 clear (it is the start bit).
                        to_gap     = 1'b1;
                        gap_target = S_ACMD41;
                    end
                    default: begin
                        gap_target = S_CMD55;
                        if (eng_resp[7:0] == R1_READY) begin
                            finish = 1'b1;
                        end else if ((eng_resp[7:0] == R1_IDLE) &&
                                     (retry != RW'(ACMD41_RETRIES - 1))) begin
                            to_gap = 1'b1;
                        end else begin
                            fail      = 1'b1;
                            fail_code = ERR_ACMD41;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_s_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_IDLE;
            gap_next <= S_CMD8;
            cnt      <= '0;
            retry    <= '0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= 8'h00;
            led_q    <= 8'h00;
        end else begin
            if (eng_r1_done) led_q <= eng_r1;
            if (fail) begin
                state   <= S_ERROR;
                code_q  <= fail_code;
                error_q <= 1'b1;
                busy_q  <= 1'b0;
                cs_n_q  <= 1'b1;
            end else if (to_gap) begin
                state    <= S_GAP;
                gap_next <= gap_target;
                cnt      <= '0;
                if (state == S_WAIT_ACMD41) retry <= retry + 1'b1;
            end else if (finish) begin
                state  <= S_DONE;
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (bus.i_start) begin
                        state  <= S_POWERUP;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        retry  <= '0;
                    end
                    S_POWERUP: begin
                        if (eng_load) begin
                            state  <= S_CMD0;
                            cs_n_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (eng_load) state <= gap_next;
                        else          cnt   <= cnt + 1'b1;
                    end
                    S_CMD0:   if (eng_sent) state <= S_WAIT_CMD0;
                    S_CMD8:   if (eng_sent) state <= S_WAIT_CMD8;
                    S_CMD55:  if (eng_sent) state <= S_WAIT_CMD55;
                    S_ACMD41: if (eng_sent) state <= S_WAIT_ACMD41;
                    default: ;
                endcase
            end
        end
    end

    assign bus.MOSI           = eng_mosi;
    assign bus.o_cs_n         = cs_n_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;
    assign bus.o_error        = error_q;
    assign bus.o_8_error_code = code_q;
    assign bus.o_8_LED        = led_q;
endmodule

// File: tb/tb_sd_spi_initializer.sv
// tb/tb_sd_spi_initializer.sv - self-checking bench for sd_spi_initializer with a behavioural SD card
module tb_sd_spi_initializer;
    localparam int DC   = 80;
    localparam int RT   = 80;
    localparam int GC   = 8;
    localparam int RETR = 4;

    localparam logic [47:0] F_CMD0   = 48'h400000000095;
    localparam logic [47:0] F_CMD8   = 48'h48000001AA87;
    localparam logic [47:0] F_CMD55  = 48'h770000000065;
    localparam logic [47:0] F_ACMD41 = 48'h694000000077;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sd_spi_initializer_if bus();

    sd_spi_initializer #(
        .DUMMY_CLOCKS(DC), .RESP_TIMEOUT(RT), .ACMD41_RETRIES(RETR), .GAP_CLOCKS(GC)
    ) dut (
        .i_s_clk (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Card configuration, written only by the stimulus process.
    logic [7:0]  c_r0;
    bit          c_silent;
    logic [39:0] c_r8;
    logic [7:0]  acmd_arr [16];
    int          acmd_n;

    // Card model state, written only by the card process.
    logic        tx_q [$];
    logic [47:0] frames [$];
    logic [47:0] rx;
    int          rx_cnt, acmd_idx, cyc, last_bit_win, err_win, pu_cnt;
    bit          rx_active, pu_bad;

    function automatic void push_resp(input logic [39:0] v, input int n);
        int lat = $urandom_range(0, 5);
        repeat (lat) tx_q.push_back(1'b1);
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
    endfunction

    function automatic void respond(input logic [5:0] idx);
        case (idx)
            6'd0:  if (!c_silent) push_resp({32'h0, c_r0}, 8);
            6'd8:  push_resp(c_r8, 40);
            6'd55: push_resp(40'h01, 8);
            6'd41: begin
                push_resp({32'h0, (acmd_idx < acmd_n) ? acmd_arr[acmd_idx] : 8'h00}, 8);
                acmd_idx++;
            end
            default: ;
        endcase
    endfunction

    // Card: looks at MOSI/CS in each bit window and puts its reply bit on MISO.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            rx_active = 0; rx_cnt = 0; acmd_idx = 0; tx_q.delete(); frames.delete();
            pu_cnt = 0; pu_bad = 0; err_win = -1; last_bit_win = -1;
            bus.MISO = 1'b1;
        end else begin
            if (bus.o_busy && bus.o_cs_n) begin
                pu_cnt++;
                if (bus.MOSI !== 1'b1) pu_bad = 1;
            end
            if (bus.o_error && err_win < 0) err_win = cyc;
            if (bus.o_cs_n) begin
                rx_active = 0; rx_cnt = 0;
            end else if (rx_active || bus.MOSI == 1'b0) begin
                rx = {rx[46:0], bus.MOSI};
                rx_cnt++;
                rx_active = 1;
                if (rx_cnt == 48) begin
                    frames.push_back(rx);
                    last_bit_win = cyc;
                    rx_active = 0; rx_cnt = 0;
                    respond(rx[45:40]);
                end
            end
            bus.MISO = (tx_q.size() > 0) ? tx_q.pop_front() : 1'b1;
        end
    end

    // Expected outcome, computed from the init rules.
    logic [47:0] exp_frames [$];
    bit          e_done;
    logic [7:0]  e_code, e_led;

    task automatic predict(input logic [7:0] r0, input bit silent, input logic [39:0] r8,
                           input int ones, input logic [7:0] fin);
        int tries = 0;
        logic [7:0] r;
        exp_frames.delete();
        exp_frames.push_back(F_CMD0);
        e_done = 0; e_led = 8'h00;
        if (silent) begin e_code = 8'h04; return; end
        e_led = r0;
        if (r0 != 8'h01) begin e_code = 8'h01; return; end
        exp_frames.push_back(F_CMD8);
        e_led = r8[39:32];
        if (r8[39:32] != 8'h01 || r8[11:0] != 12'h1AA) begin e_code = 8'h02; return; end
        for (int i = 0; i < 64; i++) begin
            exp_frames.push_back(F_CMD55);
            exp_frames.push_back(F_ACMD41);
            r = (i < ones) ? 8'h01 : ((i == ones) ? fin : 8'h00);
            e_led = r;
            if (r == 8'h00) begin e_done = 1; e_code = 8'h00; return; end
            tries++;
            if (r != 8'h01 || tries == RETR) begin e_code = 8'h03; return; end
        end
    endtask

    task automatic setup(input logic [7:0] r0, input bit silent, input logic [39:0] r8,
                         input int ones, input logic [7:0] fin);
        rst = 1'b1;
        bus.i_start = 1'b0;
        c_r0 = r0; c_silent = silent; c_r8 = r8;
        for (int i = 0; i < 16; i++) acmd_arr[i] = (i < ones) ? 8'h01 : fin;
        acmd_n = ones + 1;
        repeat (3) @(posedge clk);
    endtask

    task automatic kick();
        @(negedge clk) rst = 1'b0;
        @(negedge clk) bus.i_start = 1'b1;
        @(negedge clk) bus.i_start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(bus.o_done || bus.o_error) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL %s_finish: no done/error after %0d cycles, required one", tag, n);
        end
        @(negedge clk);
    endtask

    task automatic check_outcome(input string tag);
        chk({tag, "_done"},  bus.o_done, e_done);
        chk({tag, "_error"}, bus.o_error, !e_done);
        chk({tag, "_code"},  bus.o_8_error_code, e_code);
        chk({tag, "_led"},   bus.o_8_LED, e_led);
        chk({tag, "_cs_n"},  bus.o_cs_n, !e_done);
        chk({tag, "_busy"},  bus.o_busy, 1'b0);
        chk({tag, "_pu_clocks"}, pu_cnt, DC);
        chk({tag, "_pu_mosi_low"}, pu_bad, 1'b0);
        chk({tag, "_nframes"}, frames.size(), exp_frames.size());
        for (int i = 0; i < exp_frames.size() && i < frames.size(); i++)
            chk($sformatf("%s_frame%0d", tag, i), frames[i], exp_frames[i]);
    endtask

    typedef struct {
        logic [7:0]  r0;
        logic [39:0] r8;
        int          ones;
        logic [7:0]  fin;
        bit          x_done;
        logic [7:0]  x_code;
        int          x_pairs;
        logic [7:0]  x_led;
    } vec_t;

    vec_t tbl [9];

    initial begin
        bus.i_start = 1'b0;
        tbl[0] = '{8'h01, 40'h01000001AA, 2,  8'h00, 1, 8'h00, 3, 8'h00};
        tbl[1] = '{8'h05, 40'h01000001AA, 0,  8'h00, 0, 8'h01, 0, 8'h05};
        tbl[2] = '{8'h01, 40'h01000001AB, 0,  8'h00, 0, 8'h02, 0, 8'h01};
        tbl[3] = '{8'h01, 40'h05000001AA, 0,  8'h00, 0, 8'h02, 0, 8'h05};
        tbl[4] = '{8'h01, 40'h01000001AA, 10, 8'h01, 0, 8'h03, 4, 8'h01};
        tbl[5] = '{8'h01, 40'h01000001AA, 1,  8'h04, 0, 8'h03, 2, 8'h04};
        tbl[6] = '{8'h01, 40'h01000001AA, 3,  8'h00, 1, 8'h00, 4, 8'h00};
        tbl[7] = '{8'h01, 40'h01000001AA, 0,  8'h00, 1, 8'h00, 1, 8'h00};
        tbl[8] = '{8'h01, 40'h01FFFFF1AA, 0,  8'h00, 1, 8'h00, 1, 8'h00};

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mosi", bus.MOSI, 1'b1);
        chk("rst_cs_n", bus.o_cs_n, 1'b1);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_done", bus.o_done, 1'b0);
        chk("rst_error", bus.o_error, 1'b0);
        chk("rst_code", bus.o_8_error_code, 8'h00);
        chk("rst_led", bus.o_8_LED, 8'h00);

        // Table vectors: expectations written by hand in the table.
        for (int v = 0; v < 9; v++) begin
            setup(tbl[v].r0, 0, tbl[v].r8, tbl[v].ones, tbl[v].fin);
            exp_frames.delete();
            exp_frames.push_back(F_CMD0);
            if (tbl[v].x_code != 8'h01) exp_frames.push_back(F_CMD8);
            repeat (tbl[v].x_pairs) begin
                exp_frames.push_back(F_CMD55);
                exp_frames.push_back(F_ACMD41);
            end
            e_done = tbl[v].x_done; e_code = tbl[v].x_code; e_led = tbl[v].x_led;
            kick();
            wait_end($sformatf("vec%0d", v));
            check_outcome($sformatf("vec%0d", v));
        end

        // Silent card: timeout exactly RT windows after the last CMD0 bit.
        setup(8'h01, 1, 40'h01000001AA, 0, 8'h00);
        predict(8'h01, 1, 40'h01000001AA, 0, 8'h00);
        kick();
        wait_end("timeout");
        check_outcome("timeout");
        chk("timeout_latency", err_win - last_bit_win, RT);

        // Reset during bit 20 of CMD8, then a full replay.
        setup(8'h01, 0, 40'h01000001AA, 1, 8'h00);
        predict(8'h01, 0, 40'h01000001AA, 1, 8'h00);
        kick();
        begin
            int n = 0;
            while (!(frames.size() == 1 && rx_cnt == 20) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("midreset_reached_bit20", n < 2000, 1'b1);
        end
        chk("midreset_bit20_value", bus.MOSI, 1'b0);
        rst = 1'b1;
        #1;
        chk("midreset_mosi", bus.MOSI, 1'b1);
        chk("midreset_cs_n", bus.o_cs_n, 1'b1);
        chk("midreset_busy", bus.o_busy, 1'b0);
        repeat (3) @(posedge clk);
        kick();
        wait_end("replay");
        check_outcome("replay");

        // Randomised cards against the rule model.
        for (int k = 0; k < 15; k++) begin
            logic [7:0]  r0, r1b, fin;
            logic [39:0] r8;
            logic [11:0] echo;
            int          ones;
            r0   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 127)) : 8'h01;
            r1b  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 127)) : 8'h01;
            echo = ($urandom_range(0, 4) == 0) ? 12'($urandom) : 12'h1AA;
            r8   = {r1b, 20'($urandom), echo};
            ones = $urandom_range(0, 5);
            case ($urandom_range(0, 2))
                0:       fin = 8'h00;
                1:       fin = 8'h01;
                default: fin = 8'($urandom_range(0, 127));
            endcase
            setup(r0, 0, r8, ones, fin);
            predict(r0, 0, r8, ones, fin);
            kick();
            wait_end($sformatf("rnd%0d", k));
            check_outcome($sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
